// File: rtl/sample_cfg_pkg.sv
// Shared sample-size definitions for the USB frame sequencer and the I2S side:
// size codes, bytes-per-sample, masks and the sequencer state encoding.
package sample_cfg_pkg;

    localparam logic [3:0] SZ_8  = 4'd0;
    localparam logic [3:0] SZ_12 = 4'd1;
    localparam logic [3:0] SZ_16 = 4'd3;
    localparam logic [3:0] SZ_24 = 4'd4;
    localparam logic [3:0] SZ_32 = 4'd5;

    localparam logic [2:0] BPS_8  = 3'd1;
    localparam logic [2:0] BPS_12 = 3'd2;
    localparam logic [2:0] BPS_16 = 3'd2;
    localparam logic [2:0] BPS_24 = 3'd3;
    localparam logic [2:0] BPS_32 = 3'd4;

    localparam logic [31:0] MASK_8  = 32'h0000_00FF;
    localparam logic [31:0] MASK_12 = 32'h0000_0FFF;
    localparam logic [31:0] MASK_16 = 32'h0000_FFFF;
    localparam logic [31:0] MASK_24 = 32'h00FF_FFFF;
    localparam logic [31:0] MASK_32 = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RD_LOW    = 2'd1,
        RD_GAP    = 2'd2,
        FRAME_OUT = 2'd3
    } seq_state_e;

    // Gathers n_bytes little-endian bytes starting at slot 'first'; higher bytes read as zero.
    function automatic logic [31:0] pick_sample(input logic [63:0] slots,
                                                input logic [2:0]  first,
                                                input logic [2:0]  n_bytes);
        logic [31:0] v;
        v = 32'd0;
        for (int i = 0; i < 4; i++) begin
            if (3'(i) < n_bytes) begin
                v[8*i +: 8] = slots[8*(int'(first) + i) +: 8];
            end else begin
                v[8*i +: 8] = 8'h00;
            end
        end
        return v;
    endfunction

endpackage

// File: rtl/sample_cfg_decode.sv
// Combinational size-code decoder: bytes per sample, sample mask and support flag.
module sample_cfg_decode
    import sample_cfg_pkg::*;
(
    input  logic [3:0]  i_code,
    output logic [2:0]  o_bytes,
    output logic [31:0] o_mask,
    output logic        o_supported
);

    // Code lookup; unsupported codes decode to zero bytes and an empty mask.
    always_comb begin
        o_bytes     = 3'd0;
        o_mask      = 32'd0;
        o_supported = 1'b0;
        case (i_code)
            SZ_8:    begin o_bytes = BPS_8;  o_mask = MASK_8;  o_supported = 1'b1; end
            SZ_12:   begin o_bytes = BPS_12; o_mask = MASK_12; o_supported = 1'b1; end
            SZ_16:   begin o_bytes = BPS_16; o_mask = MASK_16; o_supported = 1'b1; end
            SZ_24:   begin o_bytes = BPS_24; o_mask = MASK_24; o_supported = 1'b1; end
            SZ_32:   begin o_bytes = BPS_32; o_mask = MASK_32; o_supported = 1'b1; end
            default: begin o_bytes = 3'd0;   o_mask = 32'd0;   o_supported = 1'b0; end
        endcase
    end

endmodule

// File: rtl/usb_stereo_frame_sequencer.sv
// Paces FT245 FIFO reads and assembles little-endian bytes into a left/right
// stereo frame handed to the I2S transmitter over valid/ready.
module usb_stereo_frame_sequencer
    import sample_cfg_pkg::*;
#(
    parameter int RD_PULSE_CYCLES = 2,
    parameter int RD_GAP_CYCLES   = 1,
    parameter int UNDERRUN_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  usb_rxf_n,
    output logic                  usb_rd_n,
    input  logic [7:0]            usb_data,
    input  logic                  enable,
    input  logic [3:0]            sample_size,
    output logic [31:0]           frame_left,
    output logic [31:0]           frame_right,
    output logic                  frame_valid,
    input  logic                  frame_ready,
    output logic                  cfg_error,
    output logic [UNDERRUN_W-1:0] underrun_count
);

    localparam logic [15:0] PULSE_LAST = 16'(RD_PULSE_CYCLES - 1);
    localparam logic [15:0] GAP_LAST   = 16'(RD_GAP_CYCLES - 1);
    localparam logic [UNDERRUN_W-1:0] UNDERRUN_MAX = {UNDERRUN_W{1'b1}};
    localparam logic [UNDERRUN_W-1:0] UNDERRUN_ONE = {{(UNDERRUN_W-1){1'b0}}, 1'b1};

    seq_state_e             r_state;
    seq_state_e             w_state_nxt;
    logic                   r_rd_n;
    logic [63:0]            r_slots;
    logic [3:0]             r_byte_cnt;
    logic [15:0]            r_pulse_cnt;
    logic [15:0]            r_gap_cnt;
    logic [2:0]             r_n;
    logic [31:0]            r_mask;
    logic [31:0]            r_left;
    logic [31:0]            r_right;
    logic                   r_valid;
    logic                   r_cfg_error;
    logic [UNDERRUN_W-1:0]  r_underrun;

    logic [2:0]             w_dec_bytes;
    logic [31:0]            w_dec_mask;
    logic                   w_dec_supported;
    logic                   w_start;
    logic                   w_capture;
    logic                   w_resume;
    logic                   w_finish;
    logic                   w_accept;

    sample_cfg_decode u_decode (
        .i_code      (sample_size),
        .o_bytes     (w_dec_bytes),
        .o_mask      (w_dec_mask),
        .o_supported (w_dec_supported)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode with one-cycle action strobes for the datapath.
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_capture   = 1'b0;
        w_resume    = 1'b0;
        w_finish    = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            IDLE: begin
                if (enable && !usb_rxf_n && w_dec_supported) begin
                    w_state_nxt = RD_LOW;
                    w_start     = 1'b1;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            RD_LOW: begin
                if (r_pulse_cnt == PULSE_LAST) begin
                    w_state_nxt = RD_GAP;
                    w_capture   = 1'b1;
                end else begin
                    w_state_nxt = RD_LOW;
                end
            end
            RD_GAP: begin
                if (r_gap_cnt != GAP_LAST) begin
                    w_state_nxt = RD_GAP;
                end else if (r_byte_cnt == {r_n, 1'b0}) begin
                    w_state_nxt = FRAME_OUT;
                    w_finish    = 1'b1;
                end else if (!usb_rxf_n) begin
                    w_state_nxt = RD_LOW;
                    w_resume    = 1'b1;
                end else begin
                    w_state_nxt = RD_GAP;
                end
            end
            FRAME_OUT: begin
                if (frame_ready) begin
                    w_state_nxt = IDLE;
                    w_accept    = 1'b1;
                end else begin
                    w_state_nxt = FRAME_OUT;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Read strobe, byte capture, frame assembly and handshake state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_n      <= 1'b1;
            r_slots     <= 64'd0;
            r_byte_cnt  <= 4'd0;
            r_pulse_cnt <= 16'd0;
            r_gap_cnt   <= 16'd0;
            r_n         <= 3'd0;
            r_mask      <= 32'd0;
            r_left      <= 32'd0;
            r_right     <= 32'd0;
            r_valid     <= 1'b0;
        end else begin
            r_rd_n <= (w_state_nxt != RD_LOW);

            if (w_start || w_resume) begin
                r_pulse_cnt <= 16'd0;
            end else if (r_state == RD_LOW && !w_capture) begin
                r_pulse_cnt <= r_pulse_cnt + 16'd1;
            end else begin
                r_pulse_cnt <= r_pulse_cnt;
            end

            // Gap counter parks at its last value so a starved FIFO can be waited on indefinitely.
            if (w_capture) begin
                r_gap_cnt <= 16'd0;
            end else if (r_state == RD_GAP && r_gap_cnt != GAP_LAST) begin
                r_gap_cnt <= r_gap_cnt + 16'd1;
            end else begin
                r_gap_cnt <= r_gap_cnt;
            end

            if (w_start) begin
                r_n        <= w_dec_bytes;
                r_mask     <= w_dec_mask;
                r_byte_cnt <= 4'd0;
            end else if (w_capture) begin
                r_byte_cnt <= r_byte_cnt + 4'd1;
                r_slots[{r_byte_cnt[2:0], 3'b000} +: 8] <= usb_data;
            end else if (w_accept) begin
                r_byte_cnt <= 4'd0;
                r_slots    <= 64'd0;
            end else begin
                r_byte_cnt <= r_byte_cnt;
            end

            if (w_finish) begin
                r_left  <= pick_sample(r_slots, 3'd0, r_n) & r_mask;
                r_right <= pick_sample(r_slots, r_n, r_n) & r_mask;
                r_valid <= 1'b1;
            end else if (w_accept) begin
                r_valid <= 1'b0;
            end else begin
                r_valid <= r_valid;
            end
        end
    end

    // Configuration error flag and saturating underrun counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cfg_error <= 1'b0;
            r_underrun  <= {UNDERRUN_W{1'b0}};
        end else begin
            if (r_state == IDLE) begin
                r_cfg_error <= !w_dec_supported;
            end else begin
                r_cfg_error <= r_cfg_error;
            end

            if (frame_ready && !r_valid && enable && (r_underrun != UNDERRUN_MAX)) begin
                r_underrun <= r_underrun + UNDERRUN_ONE;
            end else begin
                r_underrun <= r_underrun;
            end
        end
    end

    assign usb_rd_n       = r_rd_n;
    assign frame_left     = r_left;
    assign frame_right    = r_right;
    assign frame_valid    = r_valid;
    assign cfg_error      = r_cfg_error;
    assign underrun_count = r_underrun;

endmodule

// File: tb/tb_usb_stereo_frame_sequencer.sv
// Directed and randomized bench for usb_stereo_frame_sequencer with a FIFO
// responder and an arithmetic reference model of frame assembly.
module tb_usb_stereo_frame_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        usb_rxf_n = 1'b1;
    logic        usb_rd_n;
    logic [7:0]  usb_data = 8'h00;
    logic        enable = 1'b0;
    logic [3:0]  sample_size = 4'd0;
    logic [31:0] frame_left;
    logic [31:0] frame_right;
    logic        frame_valid;
    logic        frame_ready = 1'b0;
    logic        cfg_error;
    logic [15:0] underrun_count;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int base    = 0;
    int pulses  = 0;
    bit stall_en = 1'b0;
    byte unsigned feed_q[$];
    int low_q[$];

    int codes[5] = '{0, 1, 3, 4, 5};
    int bits[5]  = '{8, 12, 16, 24, 32};

    usb_stereo_frame_sequencer #(
        .RD_PULSE_CYCLES (2),
        .RD_GAP_CYCLES   (1),
        .UNDERRUN_W      (16)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .usb_rxf_n      (usb_rxf_n),
        .usb_rd_n       (usb_rd_n),
        .usb_data       (usb_data),
        .enable         (enable),
        .sample_size    (sample_size),
        .frame_left     (frame_left),
        .frame_right    (frame_right),
        .frame_valid    (frame_valid),
        .frame_ready    (frame_ready),
        .cfg_error      (cfg_error),
        .underrun_count (underrun_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // FIFO responder: present the next queued byte when the read strobe falls.
    always @(negedge usb_rd_n) begin
        if (feed_q.size() > 0) usb_data = feed_q.pop_front();
        else usb_data = 8'hEE;
    end

    always @(posedge usb_rd_n) pulses++;

    always @(negedge clk) begin
        if (usb_rd_n === 1'b0) low_q.push_back(cyc - base);
        if (stall_en) usb_rxf_n = ($urandom_range(0, 3) == 0);
    end

    // Sample value: bytes little-endian from 'first', reduced to nbits.
    function automatic logic [31:0] ref_sample(input int nbits, input byte unsigned b[$], input int first);
        longint unsigned v;
        int n;
        v = 0;
        n = (nbits + 7) / 8;
        for (int i = 0; i < n; i++) v += {56'd0, b[first + i]} << (8 * i);
        return 32'(v % (64'd1 << nbits));
    endfunction

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int k;
        k = 0;
        while (frame_valid !== 1'b1 && k < budget) begin
            tick();
            k++;
        end
        check({tag, "_valid_seen"}, 32'(frame_valid), 32'd1);
    endtask

    task automatic accept(input string tag);
        frame_ready = 1'b1;
        tick();
        frame_ready = 1'b0;
        check({tag, "_valid_drop"}, 32'(frame_valid), 32'd0);
    endtask

    task automatic run_frame(input string tag, input int ci, input byte unsigned b[$], input bit stall);
        int n;
        n = (bits[ci] + 7) / 8;
        foreach (b[i]) feed_q.push_back(b[i]);
        sample_size = 4'(codes[ci]);
        enable = 1'b1;
        stall_en = stall;
        if (!stall) usb_rxf_n = 1'b0;
        wait_valid(tag, 400);
        enable = 1'b0;
        stall_en = 1'b0;
        usb_rxf_n = 1'b1;
        check({tag, "_left"}, frame_left, ref_sample(bits[ci], b, 0));
        check({tag, "_right"}, frame_right, ref_sample(bits[ci], b, n));
        check({tag, "_consumed"}, 32'(feed_q.size()), 32'd0);
        accept(tag);
    endtask

    initial begin
        byte unsigned q[$];
        int k;
        int p0;
        logic [31:0] exp_l;
        logic [31:0] exp_r;

        #1 rst_n = 1'b0;
        tick(3);
        check("rst_rd_n", 32'(usb_rd_n), 32'd1);
        check("rst_valid", 32'(frame_valid), 32'd0);
        check("rst_left", frame_left, 32'd0);
        check("rst_right", frame_right, 32'd0);
        check("rst_cfg_error", 32'(cfg_error), 32'd0);
        check("rst_underrun", 32'(underrun_count), 32'd0);
        rst_n = 1'b1;
        tick(2);

        // 16-bit frame with exact strobe timing from the IDLE decision cycle.
        q = '{8'h34, 8'h12, 8'h78, 8'h56};
        foreach (q[i]) feed_q.push_back(q[i]);
        sample_size = 4'd3;
        base = cyc;
        low_q.delete();
        enable = 1'b1;
        usb_rxf_n = 1'b0;
        wait_valid("s16", 100);
        check("s16_valid_cycle", 32'(cyc - base), 32'd13);
        enable = 1'b0;
        usb_rxf_n = 1'b1;
        check("s16_left", frame_left, 32'h0000_1234);
        check("s16_right", frame_right, 32'h0000_5678);
        check("s16_low_cycles", 32'(low_q.size()), 32'd8);
        for (int b = 0; b < 4; b++) begin
            check("s16_low_a", 32'(low_q[2*b]), 32'(1 + 3*b));
            check("s16_low_b", 32'(low_q[2*b+1]), 32'(2 + 3*b));
        end
        accept("s16");

        q = '{8'hAB, 8'hFC, 8'h01, 8'hF2};
        run_frame("s12", 1, q, 1'b0);
        check("s12_left_const", ref_sample(12, q, 0), 32'h0000_0CAB);
        q = '{8'h12, 8'h34, 8'h56, 8'h9A, 8'hBC, 8'hDE};
        run_frame("s24", 3, q, 1'b0);
        check("s24_right_const", ref_sample(24, q, 3), 32'h00DE_BC9A);

        // 32-bit frame held by a stalled transmitter while the FIFO still has data.
        q.delete();
        for (int i = 0; i < 8; i++) q.push_back(8'($urandom));
        foreach (q[i]) feed_q.push_back(q[i]);
        sample_size = 4'd5;
        enable = 1'b1;
        usb_rxf_n = 1'b0;
        wait_valid("s32", 100);
        enable = 1'b0;
        exp_l = ref_sample(32, q, 0);
        exp_r = ref_sample(32, q, 4);
        p0 = pulses;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("hold_valid", 32'(frame_valid), 32'd1);
            check("hold_left", frame_left, exp_l);
            check("hold_right", frame_right, exp_r);
            check("hold_rd_n", 32'(usb_rd_n), 32'd1);
        end
        check("hold_no_reads", 32'(pulses - p0), 32'd0);
        usb_rxf_n = 1'b1;
        accept("s32");

        // FIFO starvation after two bytes, with a size change ignored mid-frame.
        q = '{8'hC3, 8'h5A, 8'h0F, 8'hE1};
        foreach (q[i]) feed_q.push_back(q[i]);
        sample_size = 4'd3;
        pulses = 0;
        enable = 1'b1;
        usb_rxf_n = 1'b0;
        k = 0;
        while (pulses < 2 && k < 100) begin
            tick();
            k++;
        end
        check("pause_reach", 32'(pulses), 32'd2);
        usb_rxf_n = 1'b1;
        sample_size = 4'd5;
        low_q.delete();
        tick(10);
        check("pause_no_rd", 32'(low_q.size()), 32'd0);
        usb_rxf_n = 1'b0;
        wait_valid("pause", 100);
        enable = 1'b0;
        usb_rxf_n = 1'b1;
        check("pause_left", frame_left, ref_sample(16, q, 0));
        check("pause_right", frame_right, ref_sample(16, q, 2));
        check("pause_consumed", 32'(feed_q.size()), 32'd0);
        accept("pause");

        // Unsupported code blocks reads; a supported one clears the flag.
        sample_size = 4'd2;
        enable = 1'b1;
        usb_rxf_n = 1'b0;
        low_q.delete();
        tick(5);
        check("cfg_err_set", 32'(cfg_error), 32'd1);
        check("cfg_no_rd", 32'(low_q.size()), 32'd0);
        q = '{8'h7F, 8'h80};
        run_frame("s8", 0, q, 1'b0);
        check("s8_left_const", frame_left, 32'h0000_007F);
        check("cfg_err_clear", 32'(cfg_error), 32'd0);

        for (int f = 0; f < 12; f++) begin
            int ci;
            int nb;
            ci = $urandom_range(0, 4);
            nb = (bits[ci] + 7) / 8;
            q.delete();
            for (int i = 0; i < 2 * nb; i++) q.push_back(8'($urandom));
            run_frame("rand", ci, q, 1'b1);
        end
        check("no_underrun_yet", 32'(underrun_count), 32'd0);

        // Underrun counting and saturation.
        enable = 1'b1;
        usb_rxf_n = 1'b1;
        frame_ready = 1'b1;
        tick(5);
        frame_ready = 1'b0;
        check("underrun_5", 32'(underrun_count), 32'd5);
        frame_ready = 1'b1;
        tick(65535);
        check("underrun_sat", 32'(underrun_count), 32'h0000_FFFF);
        tick(3);
        check("underrun_sat_hold", 32'(underrun_count), 32'h0000_FFFF);
        frame_ready = 1'b0;

        // Asynchronous reset during a read pulse.
        q = '{8'h11, 8'h22, 8'h33, 8'h44};
        foreach (q[i]) feed_q.push_back(q[i]);
        sample_size = 4'd3;
        usb_rxf_n = 1'b0;
        k = 0;
        while (usb_rd_n !== 1'b0 && k < 50) begin
            tick();
            k++;
        end
        check("arst_in_rd_low", 32'(usb_rd_n), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("arst_rd_n", 32'(usb_rd_n), 32'd1);
        check("arst_valid", 32'(frame_valid), 32'd0);
        check("arst_left", frame_left, 32'd0);
        check("arst_right", frame_right, 32'd0);
        check("arst_underrun", 32'(underrun_count), 32'd0);
        check("arst_cfg_error", 32'(cfg_error), 32'd0);
        enable = 1'b0;
        usb_rxf_n = 1'b1;
        tick(2);
        feed_q.delete();
        rst_n = 1'b1;
        tick(2);
        check("post_rst_rd_n", 32'(usb_rd_n), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
